// File: rtl/mem_stage_mw_if.sv
// EX/MEM-to-MEM/WB bus of the memory stage: EX/MEM fields in, registered writeback fields and stall out.
// master drives the EX/MEM side (upstream); slave is the memory stage itself.
interface mem_stage_mw_if;
  logic        regwrite_m;
  logic [1:0]  resultsrc_m;
  logic        memwrite_m;
  logic [31:0] aluresult_m;
  logic [31:0] writedata_m;
  logic [4:0]  rd_m;
  logic [31:0] pcplus4_m;
  logic        stall_m;
  logic        regwrite_w;
  logic [1:0]  resultsrc_w;
  logic [31:0] aluresult_w;
  logic [31:0] readdata_w;
  logic [4:0]  rd_w;
  logic [31:0] pcplus4_w;

  modport master (
    output regwrite_m, resultsrc_m, memwrite_m, aluresult_m, writedata_m, rd_m, pcplus4_m,
    input  stall_m, regwrite_w, resultsrc_w, aluresult_w, readdata_w, rd_w, pcplus4_w
  );

  modport slave (
    input  regwrite_m, resultsrc_m, memwrite_m, aluresult_m, writedata_m, rd_m, pcplus4_m,
    output stall_m, regwrite_w, resultsrc_w, aluresult_w, readdata_w, rd_w, pcplus4_w
  );
endinterface

// File: rtl/mem_stage_mw.sv
// Memory stage + MEM/WB register: loads/stores hold the stage MEM_LATENCY+1 cycles (stall_m freezes upstream), others pass in 1 cycle.
// Optional MEM_STATS_EN adds saturating load/store/stall counters.
module mem_stage_mw #(
  parameter int DEPTH_WORDS = 256,
  parameter int MEM_LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_stage_mw_if.slave bus
`ifdef MEM_STATS_EN
  ,
  output logic [31:0]   load_cnt_o,
  output logic [31:0]   store_cnt_o,
  output logic [31:0]   stall_cnt_o
`endif
);

  localparam int ADDR_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);
  localparam logic HAS_WAIT = (MEM_LATENCY != 0);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [31:0]       mem [DEPTH_WORDS];
  logic [ADDR_W-1:0] idx;
  logic              is_load;
  logic              access;
  logic              stall;
  logic              commit;

  assign idx     = bus.aluresult_m[ADDR_W+1:2];
  assign is_load = (bus.resultsrc_m == 2'b01);
  assign access  = bus.memwrite_m | is_load;

  // Held low during reset so an abandoned access does not keep upstream frozen.
  always_comb begin
    stall = 1'b0;
    if (rst_n) begin
      if (state == IDLE) stall = access & HAS_WAIT;
      else               stall = (cnt != 4'd0);
    end
  end

  assign bus.stall_m = stall;
  assign commit      = rst_n & bus.memwrite_m & ~stall;

  always_ff @(posedge clk) begin
    if (commit) mem[idx] <= bus.writedata_m;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= 4'd0;
      bus.regwrite_w  <= 1'b0;
      bus.resultsrc_w <= 2'b00;
      bus.aluresult_w <= 32'd0;
      bus.readdata_w  <= 32'd0;
      bus.rd_w        <= 5'd0;
      bus.pcplus4_w   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (access && HAS_WAIT) begin
            state <= WAIT;
            cnt   <= LAT_M1;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= IDLE;
          else             cnt   <= cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase

      if (stall) begin
        bus.regwrite_w  <= 1'b0;
        bus.resultsrc_w <= 2'b00;
        bus.aluresult_w <= 32'd0;
        bus.readdata_w  <= 32'd0;
        bus.rd_w        <= 5'd0;
        bus.pcplus4_w   <= 32'd0;
      end else begin
        bus.regwrite_w  <= bus.regwrite_m & (bus.rd_m != 5'd0);
        bus.resultsrc_w <= bus.resultsrc_m;
        bus.aluresult_w <= bus.aluresult_m;
        bus.readdata_w  <= is_load ? mem[idx] : 32'd0;
        bus.rd_w        <= bus.rd_m;
        bus.pcplus4_w   <= bus.pcplus4_m;
      end
    end
  end

`ifdef MEM_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt_o  <= 32'd0;
      store_cnt_o <= 32'd0;
      stall_cnt_o <= 32'd0;
    end else begin
      if (is_load && !stall && load_cnt_o != 32'hFFFF_FFFF)
        load_cnt_o <= load_cnt_o + 32'd1;
      if (bus.memwrite_m && !stall && store_cnt_o != 32'hFFFF_FFFF)
        store_cnt_o <= store_cnt_o + 32'd1;
      if (stall && stall_cnt_o != 32'hFFFF_FFFF)
        stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/mem_stage_mw.md
Name: mem_stage_mw

Overview:
- Memory stage plus MEM/WB pipeline register of the 5-stage RISC-V pipeline.
- Sits directly downstream of the EX/MEM register (reg_em) and consumes its outputs.
- Performs data-memory loads and stores against an internal word RAM with configurable access latency.
- Stalls the upstream stages while an access is in flight, then registers results for writeback.

Parameters:
DEPTH_WORDS, 256, data RAM depth in 32-bit words (power of two); ADDR_W = log2(DEPTH_WORDS)
MEM_LATENCY, 2, extra wait cycles per load/store (0 = single-cycle access, no stall)

Ports:
clk  in  1  clock, rising-edge
rst_n  in  1  asynchronous active-low reset
regwrite_m  in  1  register-write enable from EX/MEM
resultsrc_m  in  2  result select (00 ALU, 01 load, 10 PC+4)
memwrite_m  in  1  store enable
aluresult_m  in  32  effective address / ALU result
writedata_m  in  32  store data
rd_m  in  5  destination register
pcplus4_m  in  32  PC+4
stall_m  out  1  freeze PC, IF/ID, ID/EX and EX/MEM registers
regwrite_w  out  1  registered register-write enable
resultsrc_w  out  2  registered result select
aluresult_w  out  32  registered ALU result
readdata_w  out  32  registered load data
rd_w  out  5  registered destination register
pcplus4_w  out  32  registered PC+4

Behaviour:
- Single clock clk; reset rst_n is asynchronous and active-low.
- Reset:
  - All *_w outputs are 0, stall_m=0, state IDLE, wait counter 0.
  - RAM contents are not reset.
  - Reset mid-access abandons the access: no write is committed and no WB result is produced.
- Access classification: access = memwrite_m | (resultsrc_m==2'b01). Every other instruction passes through to the *_w outputs in 1 cycle with no stall.
- Address: word index = aluresult_m[ADDR_W+1:2].
  - Bits [1:0] are ignored.
  - Higher address bits are ignored, so addresses wrap modulo DEPTH_WORDS.
- FSM states IDLE and WAIT; 4-bit down-counter cnt.
  - IDLE, access, MEM_LATENCY>0: stall_m=1 (combinational); MEM/WB loads a bubble; next state WAIT with cnt=MEM_LATENCY-1.
  - WAIT, cnt!=0: stall_m=1; MEM/WB loads a bubble; cnt decrements.
  - WAIT, cnt==0: stall_m=0; the access completes at this edge; MEM/WB loads the instruction; next state IDLE.
  - MEM_LATENCY=0: every access completes in IDLE with no stall.
- Result: each access instruction holds the stage for MEM_LATENCY+1 cycles. The WB result appears MEM_LATENCY+1 edges after the instruction enters.
- Bubble: regwrite_w=0, rd_w=0, resultsrc_w=00; aluresult_w, readdata_w and pcplus4_w are 0.
- Inputs are guaranteed stable while stall_m=1, because upstream is frozen.
- Store: RAM[index] <= writedata_m, committed exactly once, at the completing edge only.
- Load: readdata_w <= RAM[index] at the completing edge.
  - A load immediately following a store to the same word returns the stored value.
  - Non-load instructions set readdata_w=0.
- x0 rule: if rd_m==0 then regwrite_w=0 regardless of regwrite_m.
- Back-to-back accesses: after a completion the FSM returns to IDLE, and the next access starts a fresh stall sequence. No cycle is lost between them beyond the latency.
- Store with regwrite_m=1 is legal: both the write commit and the WB register update occur.

Optional Feature:
MEM_STATS_EN:
- Defined: adds outputs load_cnt_o[31:0], store_cnt_o[31:0] and stall_cnt_o[31:0].
  - load_cnt_o and store_cnt_o increment on each completed load or store.
  - stall_cnt_o increments on each cycle with stall_m=1.
  - All three saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: these ports and their counter logic do not exist; all other behaviour is identical.

Test Plan:
- Reset mid-access (MEM_LATENCY=2): apply reset during WAIT of a store of 32'hDEADBEEF to 0x10 -> outputs 0 and stall_m=0 immediately; a later load of 0x10 does not return DEADBEEF.
- ALU op pass-through: aluresult_m=32'hFFFF0001, rd_m=5'b10001, regwrite_m=1, resultsrc_m=00 -> next edge aluresult_w=FFFF0001, rd_w=10001, regwrite_w=1, stall_m never 1.
- Store timing (MEM_LATENCY=2): store 32'h1000FFFF to 0x40 -> stall_m=1 for 2 cycles, WB bubbles for 2 cycles, write commits at the 3rd edge only.
- Load-after-store: load 0x40 then 0x140 with DEPTH_WORDS=64 (wrap) -> readdata_w=1000FFFF both times, resultsrc_w=01, each after 3 edges.
- x0 guard and latency-0 build: load to rd_m=0 with MEM_LATENCY=0 -> regwrite_w=0, no stall, readdata_w valid after 1 edge.
- MEM_STATS_EN: 2 stores plus 1 load at MEM_LATENCY=2 -> store_cnt_o=2, load_cnt_o=1, stall_cnt_o=6.
